// File: rtl/instr_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_enc_pkg
//  Description : Shared types, field bit positions and the instruction-word
//                encode function for the instruction encoder/loader.
//                Contents:
//                  instr_type_e  - R_TYPE / I_TYPE selector
//                  load_state_e  - load FSM states
//                  *_LSB         - field bit positions in the 32-bit word
//                  encode_instr  - packs a field set into one word
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_enc_pkg;

    typedef enum logic {
        R_TYPE = 1'b0,
        I_TYPE = 1'b1
    } instr_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

    localparam int INSTR_W   = 32;
    localparam int REG_W     = 6;
    localparam int FUNCT_W   = 4;
    localparam int IMM9_W    = 9;
    localparam int IMM15_W   = 15;

    localparam int TYPE_BIT  = 0;
    localparam int RS_LSB    = 1;
    localparam int RD_LSB    = 7;
    localparam int FUNCT_LSB = 13;
    localparam int RT_LSB    = 17;
    localparam int IMM9_LSB  = 23;
    localparam int IMM15_LSB = 17;

    // R-type and I-type share bits [16:0]; the upper 15 bits carry either
    // rt+imm9 or imm15. Fields not belonging to the selected type are dropped.
    function automatic logic [INSTR_W-1:0] encode_instr(
        input instr_type_e        t,
        input logic [REG_W-1:0]   rs,
        input logic [REG_W-1:0]   rd,
        input logic [REG_W-1:0]   rt,
        input logic [FUNCT_W-1:0] funct,
        input logic [IMM9_W-1:0]  imm9,
        input logic [IMM15_W-1:0] imm15
    );
        logic [INSTR_W-1:0] w;
        w                            = '0;
        w[TYPE_BIT]                  = t;
        w[RS_LSB    +: REG_W]        = rs;
        w[RD_LSB    +: REG_W]        = rd;
        w[FUNCT_LSB +: FUNCT_W]      = funct;
        if (t == R_TYPE) begin
            w[RT_LSB   +: REG_W]     = rt;
            w[IMM9_LSB +: IMM9_W]    = imm9;
        end else begin
            w[IMM15_LSB +: IMM15_W]  = imm15;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : enc_fifo
//  Description : Synchronous single-clock FIFO with registered full/empty.
//                Ports:
//                  clk, rst        - clock, synchronous active-high reset
//                  push_i, data_i  - write request and data
//                  pop_i, data_o   - read request; data_o shows the head
//                  full_o, empty_o - occupancy flags
//                A push while full is honoured only when a pop happens in
//                the same cycle. Reset clears the storage as well.
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign data_o    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_loader
//  Description : Encodes instruction field sets into 32-bit words, buffers
//                them in enc_fifo and writes them to instruction memory at
//                consecutive addresses starting from a programmable base.
//                Ports:
//                  clk, rst                 - clock, sync active-high reset
//                  start_i, base_addr_i     - open a session at base address
//                  finish_i                 - end of input; drain then done
//                  in_valid_i / in_ready_o  - field-set handshake
//                  in_type_i .. in_imm15_i  - decoded instruction fields
//                  mem_we_o/addr_o/wdata_o  - memory write port
//                  busy_o, done_o           - session status
//                  count_o                  - words written this session
//                  overflow_o               - sticky, a write hit addr all-ones
//                  checksum_o               - XOR of written words
//                Build option: define ENC_CHECKSUM_EN to add checksum_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic              finish_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              in_type_i,
    input  logic [5:0]        in_rs_i,
    input  logic [5:0]        in_rd_i,
    input  logic [5:0]        in_rt_i,
    input  logic [3:0]        in_funct_i,
    input  logic [8:0]        in_imm9_i,
    input  logic [14:0]       in_imm15_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W:0]   count_o,
`ifdef ENC_CHECKSUM_EN
    output logic [31:0]       checksum_o,
`endif
    output logic              overflow_o
);

    load_state_e       state_q;
    load_state_e       state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
`ifdef ENC_CHECKSUM_EN
    logic [31:0]       checksum_q;
`endif

    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [31:0] w_fifo_head;
    logic [31:0] w_enc_word;
    logic        w_push;
    logic        w_pop;
    logic        w_start;
    logic        w_active;

    assign w_active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign in_ready_o = (state_q == ST_RUN) && !w_fifo_full;
    assign w_push     = in_valid_i && in_ready_o;
    assign w_pop      = w_active && !w_fifo_empty;
    // start only opens a session from an idle or finished state
    assign w_start    = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    assign w_enc_word = encode_instr(instr_type_e'(in_type_i), in_rs_i, in_rd_i,
                                     in_rt_i, in_funct_i, in_imm9_i, in_imm15_i);

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (w_enc_word),
        .pop_i   (w_pop),
        .data_o  (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // An empty FIFO in DRAIN also means no pop this cycle, so the last
    // write's strobe is already on the outputs and done follows it directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i)      state_d = ST_RUN;
            ST_RUN:   if (finish_i)     state_d = ST_DRAIN;
            ST_DRAIN: if (w_fifo_empty) state_d = ST_DONE;
            ST_DONE:  if (start_i)      state_d = ST_RUN;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef ENC_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mem_we_q <= w_pop;
            if (w_start) begin
                ptr_q      <= base_addr_i;
                count_q    <= '0;
                overflow_q <= 1'b0;
`ifdef ENC_CHECKSUM_EN
                checksum_q <= '0;
`endif
            end else if (w_pop) begin
                mem_addr_q  <= ptr_q;
                mem_wdata_q <= w_fifo_head;
                ptr_q       <= ptr_q + ADDR_W'(1);
                count_q     <= count_q + (ADDR_W+1)'(1);
                if (ptr_q == '1) begin
                    overflow_q <= 1'b1;
                end
`ifdef ENC_CHECKSUM_EN
                checksum_q  <= checksum_q ^ w_fifo_head;
`endif
            end
        end
    end

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = w_active;
    assign done_o      = (state_q == ST_DONE);
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
`ifdef ENC_CHECKSUM_EN
    assign checksum_o  = checksum_q;
`endif

endmodule
`default_nettype wire
